// File: rtl/unary_add_ctrl_if.sv
// Request/result and unary-adder signal bundle for unary_add_ctrl.
// slave = the controller; master = requesters plus the unary adder it drives.
interface unary_add_ctrl_if;
  logic [1:0] req;
  logic [3:0] opa0;
  logic [3:0] opb0;
  logic [3:0] opa1;
  logic [3:0] opb1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [4:0] result;
  logic       busy;
  logic       add_en;
  logic       add_rw;
  logic       add_A;
  logic       add_B;
  logic       add_dout;
  logic       add_C;

  modport slave (
    input  req, opa0, opb0, opa1, opb1, add_dout, add_C,
    output gnt, done, result, busy, add_en, add_rw, add_A, add_B
  );

  modport master (
    output req, opa0, opb0, opa1, opb1, add_dout, add_C,
    input  gnt, done, result, busy, add_en, add_rw, add_A, add_B
  );
endinterface

// File: rtl/unary_add_ctrl.sv
// Two-requester controller that feeds 4-bit operands to a serial unary adder
// and collects a 5-bit result. Define UNARY_ADD_CTRL_RR_EN for round-robin ties.
module unary_add_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  unary_add_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_READ,
    S_FLUSH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       sel_q, sel_d;        // index of the requester being served
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [3:0] len_q, len_d;
  logic [3:0] k_q, k_d;            // READ cycle index
  logic [3:0] sum_q, sum_d;        // count of add_dout highs in WRITE
  logic       carry_q, carry_d;
  logic       wdog_q, wdog_d;
  logic       first_q, first_d;    // first WRITE cycle, add_dout not yet valid
  logic [4:0] result_q, result_d;
  logic       win;
  logic [3:0] op_a, op_b, op_max;

`ifdef UNARY_ADD_CTRL_RR_EN
  logic       ptr_q, ptr_d;

  assign win = (&bus.req) ? ptr_q : bus.req[1];
`else
  assign win = ~bus.req[0];
`endif

  // Operands of the winner are sampled straight from the ports during GRANT.
  assign op_a   = sel_q ? bus.opa1 : bus.opa0;
  assign op_b   = sel_q ? bus.opb1 : bus.opb0;
  assign op_max = (op_a > op_b) ? op_a : op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      ra_q     <= '0;
      rb_q     <= '0;
      len_q    <= '0;
      k_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      wdog_q   <= 1'b0;
      first_q  <= 1'b0;
      result_q <= '0;
`ifdef UNARY_ADD_CTRL_RR_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q  <= state_d;
      sel_q    <= sel_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      len_q    <= len_d;
      k_q      <= k_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      wdog_q   <= wdog_d;
      first_q  <= first_d;
      result_q <= result_d;
`ifdef UNARY_ADD_CTRL_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold value first so no path through the
    // case statement leaves one unassigned (which would infer a latch).
    state_d  = state_q;
    sel_d    = sel_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    len_d    = len_q;
    k_d      = k_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    wdog_d   = wdog_q;
    first_d  = first_q;
    result_d = result_q;
`ifdef UNARY_ADD_CTRL_RR_EN
    ptr_d    = ptr_q;
`endif

    if ((state_q == S_READ || state_q == S_FLUSH || state_q == S_WRITE) && bus.add_C)
      carry_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          sel_d   = win;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        ra_d    = op_a;
        rb_d    = op_b;
        len_d   = op_max;
        k_d     = '0;
        sum_d   = '0;
        carry_d = 1'b0;
        wdog_d  = 1'b0;
`ifdef UNARY_ADD_CTRL_RR_EN
        ptr_d   = ~sel_q;
`endif
        state_d = (op_max != 4'd0) ? S_READ : S_FLUSH;
      end

      S_READ: begin
        k_d = k_q + 4'd1;
        if (k_q == len_q - 4'd1)
          state_d = S_FLUSH;
      end

      S_FLUSH: begin
        first_d = 1'b1;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (bus.add_dout) begin
          // A 16th high sample cannot come from a legal 4-bit count.
          if (sum_q == 4'hF) begin
            wdog_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            sum_d = sum_q + 4'd1;
          end
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Result is registered on entry to DONE so it is valid alongside the pulse.
    if (state_q == S_WRITE && state_d == S_DONE)
      result_d = wdog_d ? 5'h1F : {carry_d, sum_q};
  end

  always_comb begin
    bus.gnt    = 2'b00;
    bus.done   = 2'b00;
    bus.add_en = 1'b0;
    bus.add_rw = 1'b0;
    bus.add_A  = 1'b0;
    bus.add_B  = 1'b0;
    case (state_q)
      S_GRANT: bus.gnt = {sel_q, ~sel_q};
      S_READ: begin
        bus.add_en = 1'b1;
        bus.add_A  = (k_q < ra_q);
        bus.add_B  = (k_q < rb_q);
      end
      S_FLUSH: bus.add_en = 1'b1;
      S_WRITE: begin
        bus.add_en = 1'b1;
        bus.add_rw = 1'b1;
      end
      S_DONE: bus.done = {sel_q, ~sel_q};
      default: ;
    endcase
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_unary_add_ctrl.sv
// Randomised scoreboard bench for unary_add_ctrl with a behavioural unary adder;
// expected results come from plain arithmetic on the served operands.
module tb_unary_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   gnt_cycle = 0;
  bit   stuck = 1'b0;

  typedef struct {
    logic [1:0] who;
    logic [4:0] res;
    int         lat;
  } exp_t;

  exp_t exp_q[$];

`ifdef UNARY_ADD_CTRL_RR_EN
  bit rr_ptr = 1'b0;
`endif

  unary_add_ctrl_if bus ();

  unary_add_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Unary adder: tallies A/B pulses in read, pulses add_C one cycle after a
  // wrap past 15, then replays the remaining count as a registered 1-stream.
  logic [3:0] acc;
  logic       pend;
  logic       dout_r;
  int         tmp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; pend <= 1'b0; dout_r <= 1'b0;
    end else if (!bus.add_en) begin
      acc <= '0; pend <= 1'b0; dout_r <= 1'b0;
    end else if (!bus.add_rw) begin
      tmp = int'(acc) + int'(bus.add_A) + int'(bus.add_B);
      pend   <= (tmp >= 16);
      acc    <= 4'(tmp % 16);
      dout_r <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (acc != 0) begin
        dout_r <= 1'b1;
        acc    <= acc - 4'd1;
      end else begin
        dout_r <= 1'b0;
      end
    end
  end

  assign bus.add_C    = pend;
  assign bus.add_dout = stuck ? 1'b1 : dout_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: record grant time, pop and compare on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.gnt != 2'b00) gnt_cycle = cycle;
        if (bus.done != 2'b00) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(bus.done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("done", 32'(bus.done), 32'(e.who));
            check("result", 32'(bus.result), 32'(e.res));
            check("latency", 32'(cycle - gnt_cycle), 32'(e.lat));
          end
        end
      end
    end
  end

  task automatic run_op(input logic [1:0] r, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] a1, input logic [3:0] b1, input bit stk);
    bit   w;
    bit   got;
    int   a, b, s;
    exp_t e;
`ifdef UNARY_ADD_CTRL_RR_EN
    w = (r == 2'b11) ? rr_ptr : r[1];
    rr_ptr = ~w;
`else
    w = ~r[0];
`endif
    a = w ? int'(a1) : int'(a0);
    b = w ? int'(b1) : int'(b0);
    s = a + b;
    e.who = w ? 2'b10 : 2'b01;
    e.res = stk ? 5'h1F : s[4:0];
    e.lat = 1 + ((a > b) ? a : b) + 1 + (stk ? 17 : (s % 16) + 2);
    exp_q.push_back(e);

    stuck = stk;
    bus.req = r; bus.opa0 = a0; bus.opb0 = b0; bus.opa1 = a1; bus.opb1 = b1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      got = (bus.gnt != 2'b00);
    end
    check("gnt", 32'(bus.gnt), 32'(e.who));
    if (!got) begin
      exp_q.delete();
      bus.req = 2'b00;
      return;
    end
    // Operands were latched on the edge after GRANT; disturb everything now.
    @(negedge clk);
    bus.req  = 2'($urandom_range(0, 3));
    bus.opa0 = 4'($urandom_range(0, 15)); bus.opb0 = 4'($urandom_range(0, 15));
    bus.opa1 = 4'($urandom_range(0, 15)); bus.opb1 = 4'($urandom_range(0, 15));
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      got = (bus.done != 2'b00);
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    bus.req = 2'b00;
    stuck   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    32'(bus.gnt),    32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_add_en"}, 32'(bus.add_en), 32'd0);
    check({tag, "_add_rw"}, 32'(bus.add_rw), 32'd0);
    check({tag, "_add_A"},  32'(bus.add_A),  32'd0);
    check({tag, "_add_B"},  32'(bus.add_B),  32'd0);
  endtask

  initial begin
    bit got;
    bus.req = 2'b00;
    bus.opa0 = '0; bus.opb0 = '0; bus.opa1 = '0; bus.opb1 = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Tie held for two operations: first tie after reset goes to requester 0.
    run_op(2'b11, 4'd2, 4'd6, 4'd7, 4'd1, 1'b0);
    run_op(2'b11, 4'd5, 4'd5, 4'd1, 4'd1, 1'b0);

    run_op(2'b01, 4'd3, 4'd5, 4'd0, 4'd0, 1'b0);   // 8, latency 17
    run_op(2'b10, 4'd0, 4'd0, 4'd9, 4'd9, 1'b0);   // carry, 18
    run_op(2'b01, 4'd0, 4'd0, 4'd4, 4'd4, 1'b0);   // zero length, latency 4
    run_op(2'b01, 4'd15, 4'd15, 4'd0, 4'd0, 1'b0); // 30
    run_op(2'b10, 4'd1, 4'd1, 4'd8, 4'd8, 1'b0);   // exactly 16
    run_op(2'b01, 4'd15, 4'd0, 4'd3, 4'd3, 1'b0);  // 15, no carry

    // Reset in the middle of READ: no done, outputs return to reset values.
    bus.req = 2'b01; bus.opa0 = 4'd12; bus.opb0 = 4'd7;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      got = (bus.gnt != 2'b00);
    end
    check("abort_gnt", 32'(bus.gnt), 32'd1);
    repeat (4) @(negedge clk);
    check("abort_in_read", 32'(bus.add_en & ~bus.add_rw), 32'd1);
    rst_n = 1'b0;
    bus.req = 2'b00;
    @(negedge clk);
    check_reset_outputs("abort");
`ifdef UNARY_ADD_CTRL_RR_EN
    rr_ptr = 1'b0;
`endif
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    run_op(2'b01, 4'd6, 4'd4, 4'd0, 4'd0, 1'b0);

    // add_dout stuck high: watchdog ends WRITE after 16 high samples.
    run_op(2'b01, 4'd2, 4'd3, 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    check("busy_after_wdog", 32'(bus.busy), 32'd0);

    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom_range(1, 3)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
